// File: rtl/fsm_vedacao_pkg.sv
// Shared constants for the bottling-line stages: state encodings, clock rate and LED indices.
// Imported by the capping stage (fsm_vedacao) and its timer.
package fsm_vedacao_pkg;

    typedef logic [1:0] estado_t;

    // The IDLE / active / CONCLUIDO encodings match the fill stage (fsm_enchimento).
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_VEDANDO   = 2'd1;
    localparam logic [1:0] ST_CONCLUIDO = 2'd2;
    localparam logic [1:0] ST_SEM_ROLHA = 2'd3;

    localparam int CLK_HZ          = 50_000_000;
    localparam int LED_ATUADOR_IDX = 7;
    localparam int LED_ALARME_IDX  = 9;

endpackage

// File: rtl/fsm_vedacao_if.sv
// Level handshake between the master sequencer and the capping stage, plus status outputs.
// master: the sequencer side; slave: the capping FSM side.
interface fsm_vedacao_if #(
    parameter int ESTOQUE_W = 5
);
    logic                 cmd_iniciar;
    logic                 reabastecer;
    logic                 atuador_ativo;
    logic                 tarefa_concluida;
    logic                 alarme_sem_rolha;
    logic [ESTOQUE_W-1:0] estoque;

    modport master (
        output cmd_iniciar,
        output reabastecer,
        input  atuador_ativo,
        input  tarefa_concluida,
        input  alarme_sem_rolha,
        input  estoque
    );

    modport slave (
        input  cmd_iniciar,
        input  reabastecer,
        output atuador_ativo,
        output tarefa_concluida,
        output alarme_sem_rolha,
        output estoque
    );
endinterface

// File: rtl/fsm_vedacao_temporizador.sv
// Actuator on-time counter with clear/enable and a registered terminal-count flag.
// fim is high exactly while the count equals T_VEDACAO-1.
module temporizador_vedacao #(
    parameter int T_VEDACAO = 50_000_000,
    parameter int CNT_W     = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic fim
);
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(T_VEDACAO - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_inc;
    logic             fim_reg;

    assign count_inc = count_reg + 1'b1;

    // The flag is computed from the incremented value so it lines up with the count itself.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
            fim_reg   <= 1'b0;
        end else if (enable) begin
            count_reg <= count_inc;
            fim_reg   <= (count_inc == ULTIMO);
        end
    end

    assign fim = fim_reg;

endmodule

// File: rtl/fsm_vedacao.sv
// Capping stage Moore FSM: timed actuator, cap stock counter and done handshake to the master.
// Define VEDACAO_ESTOQUE_EN to enable stock counting, refill and the out-of-caps alarm.
module fsm_vedacao
    import fsm_vedacao_pkg::*;
#(
    parameter int T_VEDACAO   = 50_000_000,
    parameter int CNT_W       = 26,
    parameter int ESTOQUE_MAX = 20,
    parameter int ESTOQUE_W   = 5
) (
    input  logic          clk,
    input  logic          reset,
    fsm_vedacao_if.slave  bus
);
    localparam logic [ESTOQUE_W-1:0] ESTOQUE_CHEIO = ESTOQUE_W'(ESTOQUE_MAX);

    estado_t state_reg;
    estado_t state_next;
    logic    timer_clear;
    logic    timer_fim;
    logic    estoque_vazio;

    temporizador_vedacao #(
        .T_VEDACAO (T_VEDACAO),
        .CNT_W     (CNT_W)
    ) u_temporizador (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (state_reg == ST_VEDANDO),
        .fim    (timer_fim)
    );

`ifdef VEDACAO_ESTOQUE_EN
    logic [ESTOQUE_W-1:0] estoque_reg;

    // A refill overrides the end-of-cycle decrement on the same edge.
    always_ff @(posedge clk) begin
        if (reset || bus.reabastecer) begin
            estoque_reg <= ESTOQUE_CHEIO;
        end else if (state_reg == ST_VEDANDO && timer_fim) begin
            estoque_reg <= estoque_reg - 1'b1;
        end
    end

    assign estoque_vazio    = (estoque_reg == '0);
    assign bus.estoque      = estoque_reg;
    assign bus.alarme_sem_rolha = (state_reg == ST_SEM_ROLHA);
`else
    logic unused_reabastecer;

    assign unused_reabastecer   = bus.reabastecer;
    assign estoque_vazio        = 1'b0;
    assign bus.estoque          = ESTOQUE_CHEIO;
    assign bus.alarme_sem_rolha = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        timer_clear = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.cmd_iniciar) begin
                    if (estoque_vazio) begin
                        state_next = ST_SEM_ROLHA;
                    end else begin
                        state_next  = ST_VEDANDO;
                        timer_clear = 1'b1;
                    end
                end
            end
            // The cap press always finishes once started, whatever cmd_iniciar does.
            ST_VEDANDO: begin
                if (timer_fim) begin
                    state_next = ST_CONCLUIDO;
                end
            end
            ST_CONCLUIDO: begin
                if (!bus.cmd_iniciar) begin
                    state_next = ST_IDLE;
                end
            end
`ifdef VEDACAO_ESTOQUE_EN
            ST_SEM_ROLHA: begin
                if (bus.reabastecer) begin
                    if (bus.cmd_iniciar) begin
                        state_next  = ST_VEDANDO;
                        timer_clear = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign bus.atuador_ativo    = (state_reg == ST_VEDANDO);
    assign bus.tarefa_concluida = (state_reg == ST_CONCLUIDO);

endmodule
